// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that adds one DIGIT-bit chunk per clock,
// LSB chunk first, with a start/busy/done handshake and a registered inter-chunk carry.
module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_in_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_out_o,
  output logic             ovf_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  part_q, part_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;

  logic [DIGIT:0]    chunk_s;
  logic              last_s;
  logic              msb_cin_s;
  logic              accept_s;

  // Operand registers shift right each RUN cycle, so the active chunk is always the low DIGIT bits.
  assign chunk_s   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
  assign last_s    = (cnt_q == CW'(N - 1));
  assign msb_cin_s = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ chunk_s[DIGIT-1];
  assign accept_s  = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Next-state, datapath and result-commit logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : c_in_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = chunk_s[DIGIT];
        // New chunk enters at the top; after N shifts chunk 0 sits at the bottom.
        part_d  = (part_q >> DIGIT) | (WIDTH'(chunk_s[DIGIT-1:0]) << (WIDTH - DIGIT));
        cnt_d   = cnt_q + CW'(1);
        if (last_s) begin
          sum_d   = part_d;
          c_out_d = chunk_s[DIGIT];
          ovf_d   = msb_cin_s ^ chunk_s[DIGIT];
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy_o  = (state_q == S_RUN);
  assign done_o  = (state_q == S_DONE);
  assign sum_o   = sum_q;
  assign c_out_o = c_out_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Directed and random checks of serial_chunk_adder at DIGIT=4, 16 and 1 (WIDTH=16).
module tb_serial_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_s;
  logic        sub_s;
  logic        cin_s;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic        busy_w [3];
  logic        done_w [3];
  logic        cout_w [3];
  logic        ovf_w  [3];
  logic [15:0] sum_w  [3];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[0]), .sub_i(sub_s), .a_i(a_s), .b_i(b_s),
    .c_in_i(cin_s), .busy_o(busy_w[0]), .done_o(done_w[0]), .sum_o(sum_w[0]),
    .c_out_o(cout_w[0]), .ovf_o(ovf_w[0]));

  serial_chunk_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[1]), .sub_i(sub_s), .a_i(a_s), .b_i(b_s),
    .c_in_i(cin_s), .busy_o(busy_w[1]), .done_o(done_w[1]), .sum_o(sum_w[1]),
    .c_out_o(cout_w[1]), .ovf_o(ovf_w[1]));

  serial_chunk_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .start_i(start_s[2]), .sub_i(sub_s), .a_i(a_s), .b_i(b_s),
    .c_in_i(cin_s), .busy_o(busy_w[2]), .done_o(done_w[2]), .sum_o(sum_w[2]),
    .c_out_o(cout_w[2]), .ovf_o(ovf_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation on DUT w; inputs are scrambled after acceptance to prove capture.
  task automatic run(input int w, input logic [15:0] a, input logic [15:0] b, input logic ci,
                     input logic sb, input logic [15:0] es, input logic ec, input logic eo,
                     input int lat, input string tag);
    int cyc;
    @(negedge clk);
    a_s = a; b_s = b; cin_s = ci; sub_s = sb; start_s[w] = 1'b1;
    @(posedge clk); #1;
    start_s[w] = 1'b0;
    a_s = ~a; b_s = ~b; cin_s = ~ci; sub_s = ~sb;
    chk({tag, "_busy"}, busy_w[w], 1'b1);
    cyc = 0;
    while (!done_w[w] && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_sum"}, sum_w[w], es);
    chk({tag, "_cout"}, cout_w[w], ec);
    chk({tag, "_ovf"}, ovf_w[w], eo);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done_w[w], 1'b0);
  endtask

  initial begin
    logic [15:0] ra, rb, rbb;
    logic        rc, rs, rcc, rov;
    logic [16:0] tot;
    int          pulses;

    rst = 1'b1; start_s = 3'b000; sub_s = 1'b0; cin_s = 1'b0; a_s = 16'h0000; b_s = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 3; w++) begin
      chk("rst_busy", busy_w[w], 1'b0);
      chk("rst_done", done_w[w], 1'b0);
      chk("rst_sum", sum_w[w], 16'h0000);
      chk("rst_cout", cout_w[w], 1'b0);
      chk("rst_ovf", ovf_w[w], 1'b0);
    end
    rst = 1'b0;

    run(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4, "wrap");
    run(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "sovf");
    run(0, 16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0, 4, "cin");
    run(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4, "plain");
    run(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4, "sub_neg");
    run(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4, "sub_ovf");
    run(0, 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4, "sub_zero");

    // Handshake: start mid-RUN ignored, start in DONE accepted back-to-back.
    @(negedge clk);
    a_s = 16'h0001; b_s = 16'h0002; cin_s = 1'b0; sub_s = 1'b0; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_s = 16'hFFFF; b_s = 16'hFFFF; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    chk("hs_no_early_done", done_w[0], 1'b0);
    @(posedge clk); #1;
    chk("hs_done1", done_w[0], 1'b1);
    chk("hs_sum1", sum_w[0], 16'h0003);
    a_s = 16'h0010; b_s = 16'h0020; start_s[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start_s[0] = 1'b0;
        chk("hs_busy2", busy_w[0], 1'b1);
        chk("hs_sum_held", sum_w[0], 16'h0003);
      end
      chk("hs_done2_timing", done_w[0], (k == 5) ? 1'b1 : 1'b0);
    end
    chk("hs_sum2", sum_w[0], 16'h0030);

    // Reset two cycles into RUN discards the operation.
    @(negedge clk);
    a_s = 16'h1111; b_s = 16'h2222; start_s[0] = 1'b1;
    @(posedge clk); #1;
    start_s[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_busy", busy_w[0], 1'b0);
    chk("mrst_done", done_w[0], 1'b0);
    chk("mrst_sum", sum_w[0], 16'h0000);
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done_w[0]) pulses++;
    end
    chk("mrst_no_pulse", pulses, 0);
    run(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0, 4, "post_rst");

    run(1, 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1, "d16");
    run(1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1, "d16_sub");
    run(2, 16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 16, "d1");
    run(2, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 16, "d1_sub");

    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      rs  = (i >= 500);
      rbb = rs ? ~rb : rb;
      rcc = rs ? 1'b1 : rc;
      tot = {1'b0, ra} + {1'b0, rbb} + {16'h0000, rcc};
      rov = (ra[15] == rbb[15]) && (tot[15] != ra[15]);
      run(0, ra, rb, rc, rs, tot[15:0], tot[16], rov, 4, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
